// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT datapath and its scheduler.
// Holds the FSM state encoding, default transform size and the butterfly
// datapath latency so every block that depends on it agrees.
package fft_pkg;

    // Default log2 of the transform size (N = 32).
    localparam int FFT_LOG2_N_DEF = 5;

    // Read-issue to write-back latency of the butterfly datapath:
    // sync RAM read + twiddle ROM + CORDIC + add/sub.
    localparam int FFT_DP_LAT = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    // Sample RAM address width for a given transform size.
    function automatic int fft_addr_w(input int log2n);
        return log2n;
    endfunction

    // Twiddle ROM index width (N/2 entries).
    function automatic int fft_tw_w(input int log2n);
        return log2n - 1;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth valid+data shift register with asynchronous active-low reset.
// Used to carry side-band data (e.g. write-back addresses) alongside a
// pipelined datapath; the output lags the input by exactly DEPTH cycles.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int DEPTH  = FFT_DP_LAT,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];

    // Shift valid and data one stage per cycle; reset drops every in-flight entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= valid_i;
            r_data[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign valid_o = r_valid[DEPTH-1];
    assign data_o  = r_data[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// Butterfly issue sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2_N stages of N/2 butterflies, one issue per cycle, then drains
// the datapath for PIPE_LAT cycles before the next stage so no stale data is
// read. Write-back addresses are the read addresses delayed by PIPE_LAT.
// Optional: define FFT_BFLY_SCHED_PERF_EN to add perf_cycles_o, a saturating
// count of busy cycles of the most recent transform.
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter int  LOG2_N   = FFT_LOG2_N_DEF,
    parameter int  PIPE_LAT = FFT_DP_LAT,
    localparam int ADDR_W   = fft_addr_w(LOG2_N),
    localparam int TW_W     = fft_tw_w(LOG2_N),
    localparam int STG_W    = $clog2(LOG2_N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_a_addr_o,
    output logic [ADDR_W-1:0] rd_b_addr_o,
    output logic [TW_W-1:0]   tw_idx_o,
    output logic [STG_W-1:0]  stage_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_a_addr_o,
    output logic [ADDR_W-1:0] wr_b_addr_o
`ifdef FFT_BFLY_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_cycles_o
`endif
);

    localparam int               DR_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [TW_W-1:0]  K_LAST   = TW_W'((2 ** (LOG2_N - 1)) - 1);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(PIPE_LAT - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2_N - 1);

    fft_state_e        r_state;
    fft_state_e        w_state_nxt;
    logic [TW_W-1:0]   r_k;
    logic [TW_W-1:0]   w_k_nxt;
    logic [STG_W-1:0]  r_stage;
    logic [STG_W-1:0]  w_stage_nxt;
    logic [DR_W-1:0]   r_drain;
    logic [DR_W-1:0]   w_drain_nxt;

    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_a;
    logic [ADDR_W-1:0] r_rd_b;
    logic [TW_W-1:0]   r_tw;

    logic [ADDR_W-1:0] w_kx;
    logic [ADDR_W-1:0] w_half;
    logic [ADDR_W-1:0] w_pos;
    logic [ADDR_W-1:0] w_grp;
    logic [ADDR_W-1:0] w_rd_a;
    logic [ADDR_W-1:0] w_rd_b;
    logic [STG_W-1:0]  w_tw_sh;
    logic [ADDR_W-1:0] w_tw_full;

    logic                w_wr_valid;
    logic [2*ADDR_W-1:0] w_wr_data;

    // Next-state and counter update: issue N/2 butterflies, drain, next stage.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        w_drain_nxt = r_drain;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                    w_k_nxt     = '0;
                    w_stage_nxt = '0;
                    w_drain_nxt = '0;
                end
            end
            ST_RUN: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain == DR_LAST) begin
                    w_drain_nxt = '0;
                    if (r_stage == STG_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_stage_nxt = r_stage + 1'b1;
                        w_k_nxt     = '0;
                    end
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_stage_nxt = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Butterfly addressing for the upcoming issue; the group index is shifted
    // in two steps so stage+1 never overflows the stage width.
    always_comb begin
        w_kx      = {1'b0, w_k_nxt};
        w_half    = ADDR_W'(1) << w_stage_nxt;
        w_pos     = w_kx & (w_half - ADDR_W'(1));
        w_grp     = w_kx >> w_stage_nxt;
        w_rd_a    = ((w_grp << w_stage_nxt) << 1) | w_pos;
        w_rd_b    = w_rd_a | w_half;
        w_tw_sh   = STG_LAST - w_stage_nxt;
        w_tw_full = w_pos << w_tw_sh;
    end

    // State, counters and registered issue outputs; addresses are zero when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_stage <= w_stage_nxt;
            r_drain <= w_drain_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_rd_en <= (w_state_nxt == ST_RUN);
            r_rd_a  <= (w_state_nxt == ST_RUN) ? w_rd_a : '0;
            r_rd_b  <= (w_state_nxt == ST_RUN) ? w_rd_b : '0;
            r_tw    <= (w_state_nxt == ST_RUN) ? w_tw_full[TW_W-1:0] : '0;
        end
    end

    fft_addr_delay #(
        .DEPTH  (PIPE_LAT),
        .DATA_W (2 * ADDR_W)
    ) u_wr_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (r_rd_en),
        .data_i  ({r_rd_a, r_rd_b}),
        .valid_o (w_wr_valid),
        .data_o  (w_wr_data)
    );

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rd_en_o     = r_rd_en;
    assign rd_a_addr_o = r_rd_a;
    assign rd_b_addr_o = r_rd_b;
    assign tw_idx_o    = r_tw;
    assign stage_o     = r_stage;
    assign wr_en_o     = w_wr_valid;
    assign wr_a_addr_o = w_wr_data[2*ADDR_W-1:ADDR_W];
    assign wr_b_addr_o = w_wr_data[ADDR_W-1:0];

`ifdef FFT_BFLY_SCHED_PERF_EN
    logic [15:0] r_perf;

    // Busy-cycle counter: cleared on an accepted start, frozen once busy drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_perf <= '0;
        end else if (r_busy && r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles_o = r_perf;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed self-checking bench for fft_bfly_sched with LOG2_N=3, PIPE_LAT=2.
// Cycle numbering: the edge that samples start_i ends cycle 0, so the first
// issue appears in cycle 1. Outputs are sampled 1 time unit after each edge.
module tb_fft_bfly_sched;

    localparam int LOG2_N   = 3;
    localparam int PIPE_LAT = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       rd_en_o;
    logic [2:0] rd_a_addr_o;
    logic [2:0] rd_b_addr_o;
    logic [1:0] tw_idx_o;
    logic [1:0] stage_o;
    logic       wr_en_o;
    logic [2:0] wr_a_addr_o;
    logic [2:0] wr_b_addr_o;
`ifdef FFT_BFLY_SCHED_PERF_EN
    logic [15:0] perf_cycles_o;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed issue table: stage 0, stage 1, stage 2.
    int expA [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int expB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int expT [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_bfly_sched #(
        .LOG2_N   (LOG2_N),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_a_addr_o (rd_a_addr_o),
        .rd_b_addr_o (rd_b_addr_o),
        .tw_idx_o    (tw_idx_o),
        .stage_o     (stage_o),
        .wr_en_o     (wr_en_o),
        .wr_a_addr_o (wr_a_addr_o),
        .wr_b_addr_o (wr_b_addr_o)
`ifdef FFT_BFLY_SCHED_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    // Hold reset, check every output is zero, then release into idle.
    task automatic test_reset();
        rst_ni  = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({busy_o, done_o, rd_en_o, wr_en_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_strobes got %b exp 0000", {busy_o, done_o, rd_en_o, wr_en_o});
        end
        checks++;
        if ({rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_rd_fields got %h exp 0", {rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o});
        end
        checks++;
        if ({wr_a_addr_o, wr_b_addr_o} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_wr_addr got %h exp 0", {wr_a_addr_o, wr_b_addr_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset busy got %b exp 0", busy_o);
        end
    endtask

    // Full transform with per-cycle checks; optionally re-pulse start in cycle 5.
    task automatic test_schedule(input bit repulse);
        int         stg, off, idx, wstg, woff, widx;
        bit         expRd, expWr, expBusy, expDone;
        logic [2:0] ea, eb;
        logic [1:0] et, es;
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int c = 1; c <= 20; c++) begin
            start_i = repulse && (c == 5);
            stg     = (c - 1) / 6;
            off     = (c - 1) % 6;
            idx     = stg * 4 + off;
            expRd   = (c <= 18) && (off < 4);
            wstg    = (c - 3) / 6;
            woff    = (c - 3) % 6;
            widx    = wstg * 4 + woff;
            expWr   = (c >= 3) && (c <= 18) && (woff < 4);
            expBusy = (c <= 19);
            expDone = (c == 19);
            checks++;
            if (rd_en_o !== expRd) begin
                errors++;
                $display("[TB] FAIL rd_en rep=%0d c=%0d got %b exp %b", repulse, c, rd_en_o, expRd);
            end
            if (expRd) begin
                ea = 3'(expA[idx]);
                eb = 3'(expB[idx]);
                et = 2'(expT[idx]);
                checks++;
                if ({rd_a_addr_o, rd_b_addr_o, tw_idx_o} !== {ea, eb, et}) begin
                    errors++;
                    $display("[TB] FAIL rd_abt rep=%0d c=%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)",
                             repulse, c, rd_a_addr_o, rd_b_addr_o, tw_idx_o, ea, eb, et);
                end
            end
            if (c != 19) begin
                es = (c == 20) ? 2'd0 : 2'(stg);
                checks++;
                if (stage_o !== es) begin
                    errors++;
                    $display("[TB] FAIL stage rep=%0d c=%0d got %0d exp %0d", repulse, c, stage_o, es);
                end
            end
            checks++;
            if (wr_en_o !== expWr) begin
                errors++;
                $display("[TB] FAIL wr_en rep=%0d c=%0d got %b exp %b", repulse, c, wr_en_o, expWr);
            end
            if (expWr) begin
                ea = 3'(expA[widx]);
                eb = 3'(expB[widx]);
                checks++;
                if ({wr_a_addr_o, wr_b_addr_o} !== {ea, eb}) begin
                    errors++;
                    $display("[TB] FAIL wr_addr rep=%0d c=%0d got (%0d,%0d) exp (%0d,%0d)",
                             repulse, c, wr_a_addr_o, wr_b_addr_o, ea, eb);
                end
            end
            checks++;
            if (busy_o !== expBusy) begin
                errors++;
                $display("[TB] FAIL busy rep=%0d c=%0d got %b exp %b", repulse, c, busy_o, expBusy);
            end
            checks++;
            if (done_o !== expDone) begin
                errors++;
                $display("[TB] FAIL done rep=%0d c=%0d got %b exp %b", repulse, c, done_o, expDone);
            end
`ifdef FFT_BFLY_SCHED_PERF_EN
            if (c == 20) begin
                checks++;
                if (perf_cycles_o !== 16'd19) begin
                    errors++;
                    $display("[TB] FAIL perf_cycles got %0d exp 19", perf_cycles_o);
                end
            end
`endif
            @(posedge clk_i);
            #1;
        end
        start_i = 1'b0;
    endtask

    // Start in cycle 21 after a completed run: first issue must be cycle 22, done at 40.
    task automatic test_restart();
        int cyc;
        int doneCyc;
        int doneCnt;
        cyc     = 21;
        doneCyc = -1;
        doneCnt = 0;
        start_i = 1'b1;
        checks++;
        if ({rd_en_o, busy_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL restart_pre got rd_en,busy=%b exp 00", {rd_en_o, busy_o});
        end
        @(posedge clk_i);
        #1;
        cyc     = 22;
        start_i = 1'b0;
        checks++;
        if ({rd_en_o, busy_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o} !== {1'b1, 1'b1, 3'd0, 3'd1, 2'd0}) begin
            errors++;
            $display("[TB] FAIL restart_first got en=%b busy=%b (%0d,%0d,%0d) exp en=1 busy=1 (0,1,0)",
                     rd_en_o, busy_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o);
        end
        for (int i = 0; i < 40 && doneCyc < 0; i++) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (done_o === 1'b1) begin
                doneCyc = cyc;
                doneCnt++;
            end
        end
        checks++;
        if (doneCyc != 40) begin
            errors++;
            $display("[TB] FAIL restart_done_cycle got %0d exp 40", doneCyc);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL restart_idle got busy,done=%b exp 00", {busy_o, done_o});
        end
    endtask

    // Reset in cycle 8 aborts the transform; nothing may follow until a new start.
    task automatic test_reset_abort();
        int strayWr;
        int strayRd;
        strayWr = 0;
        strayRd = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #1;
        checks++;
        if ({rd_en_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o} !== {1'b1, 3'd1, 3'd3, 2'd2, 2'd1}) begin
            errors++;
            $display("[TB] FAIL abort_pre_c8 got en=%b (%0d,%0d,%0d) stg=%0d exp en=1 (1,3,2) stg=1",
                     rd_en_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, rd_en_o, wr_en_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o,
             wr_a_addr_o, wr_b_addr_o} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL abort_async_clear got %h exp 0",
                     {busy_o, done_o, rd_en_o, wr_en_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o,
                      wr_a_addr_o, wr_b_addr_o});
        end
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i);
            #1;
            if (wr_en_o !== 1'b0) strayWr++;
            if (rd_en_o !== 1'b0 || busy_o !== 1'b0) strayRd++;
        end
        checks++;
        if (strayWr != 0) begin
            errors++;
            $display("[TB] FAIL abort_stray_wr got %0d cycles exp 0", strayWr);
        end
        checks++;
        if (strayRd != 0) begin
            errors++;
            $display("[TB] FAIL abort_stray_rd_busy got %0d cycles exp 0", strayRd);
        end
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checks++;
        if ({rd_en_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o} !== {1'b1, 3'd0, 3'd1, 2'd0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL abort_fresh_start got en=%b (%0d,%0d,%0d) stg=%0d exp en=1 (0,1,0) stg=0",
                     rd_en_o, rd_a_addr_o, rd_b_addr_o, tw_idx_o, stage_o);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        test_reset();
        test_schedule(1'b0);
        test_restart();
        test_schedule(1'b1);
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running exp finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
